// File: rtl/mag_pkg.sv
// rtl/mag_pkg.sv - shared types and helpers for the SAR magnitude search
package mag_pkg;

    // Search controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SRCH = 2'd1,
        DONE = 2'd2
    } mag_sar_state_t;

    // Widest searched value the trial-mask helper can produce
    localparam int MAG_MAX_WIDTH = 64;

    // One-hot mask with only bit idx set; callers truncate to their width
    function automatic logic [MAG_MAX_WIDTH-1:0] trial_mask(input int unsigned idx);
        logic [MAG_MAX_WIDTH-1:0] one;
        one = {{(MAG_MAX_WIDTH-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/mag_cmp_base.sv
// rtl/mag_cmp_base.sv - combinational unsigned magnitude comparator
module mag_cmp_base #(
    parameter int WIDTH          = 32,
    parameter int IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0] val,
    input  logic [WIDTH-1:0] rfr,
    output logic             grt,
    output logic             lst
);

    generate
        if (IMPLEMENTATION == 0) begin : g_direct
            assign grt = (val > rfr);
            assign lst = (val < rfr);
        end else begin : g_subtract
            // Borrow of val - rfr flags val < rfr; a non-zero difference without borrow flags val > rfr
            logic [WIDTH:0] w_diff;
            assign w_diff = {1'b0, val} - {1'b0, rfr};
            assign lst    = w_diff[WIDTH];
            assign grt    = !w_diff[WIDTH] && (|w_diff[WIDTH-1:0]);
        end
    endgenerate

endmodule

// File: rtl/mag_sar_top.sv
// rtl/mag_sar_top.sv - search core closed around the base comparator
module mag_sar_top #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] val,
    input  logic             req_vld,
    output logic             req_rdy,
    output logic [WIDTH-1:0] rfr,
    output logic             rsp_vld,
    input  logic             rsp_rdy,
    output logic [WIDTH-1:0] rsp_val
);

    logic [WIDTH-1:0] w_rfr;
    logic             w_grt;
    logic             w_lst;

    mag_sar_search #(.WIDTH(WIDTH)) u_search (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_vld (req_vld),
        .req_rdy (req_rdy),
        .rfr     (w_rfr),
        .grt     (w_grt),
        .lst     (w_lst),
        .rsp_vld (rsp_vld),
        .rsp_rdy (rsp_rdy),
        .rsp_val (rsp_val)
    );

    mag_cmp_base #(.WIDTH(WIDTH), .IMPLEMENTATION(0)) u_cmp (
        .val (val),
        .rfr (w_rfr),
        .grt (w_grt),
        .lst (w_lst)
    );

    assign rfr = w_rfr;

endmodule

// File: rtl/mag_sar_search.sv
// rtl/mag_sar_search.sv - MSB-first successive-approximation search core (option: MAG_SAR_SEARCH_EARLY_EXIT_EN)
module mag_sar_search
    import mag_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_vld,
    output logic             req_rdy,
    output logic [WIDTH-1:0] rfr,
    input  logic             grt,
    input  logic             lst,
    output logic             rsp_vld,
    input  logic             rsp_rdy,
    output logic [WIDTH-1:0] rsp_val
);

    localparam int              IDXW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(WIDTH - 1);

    mag_sar_state_t   r_state;
    logic [WIDTH-1:0] r_acc;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_rfr;
    logic [WIDTH-1:0] r_rsp_val;
    logic             r_rsp_vld;
    logic             r_req_rdy;

    logic [WIDTH-1:0] w_acc_new;
    logic [IDXW-1:0]  w_idx_dec;
    logic [WIDTH-1:0] w_next_mask;
    logic [WIDTH-1:0] w_top_mask;

    // The current trial is acc with the bit under test set, so keeping the bit means taking rfr
    assign w_acc_new   = lst ? r_acc : r_rfr;
    assign w_idx_dec   = r_idx - IDXW'(1);
    assign w_next_mask = WIDTH'(trial_mask(32'(w_idx_dec)));
    assign w_top_mask  = WIDTH'(trial_mask(32'(IDX_TOP)));

`ifndef MAG_SAR_SEARCH_EARLY_EXIT_EN
    // Without early exit equality simply keeps the bit, so grt carries no extra information
    logic w_unused_grt;
    assign w_unused_grt = grt;
`endif

    // Search controller: accept, resolve one bit per cycle, hold the result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_idx     <= '0;
            r_rfr     <= '0;
            r_rsp_val <= '0;
            r_rsp_vld <= 1'b0;
            r_req_rdy <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_vld && r_req_rdy) begin
                        r_state   <= SRCH;
                        r_req_rdy <= 1'b0;
                        r_acc     <= '0;
                        r_idx     <= IDX_TOP;
                        r_rfr     <= w_top_mask;
                    end
                end
                SRCH: begin
`ifdef MAG_SAR_SEARCH_EARLY_EXIT_EN
                    if (!grt && !lst) begin
                        r_state   <= DONE;
                        r_rsp_val <= r_rfr;
                        r_rsp_vld <= 1'b1;
                    end else
`endif
                    if (r_idx != '0) begin
                        r_acc <= w_acc_new;
                        r_idx <= w_idx_dec;
                        r_rfr <= w_acc_new | w_next_mask;
                    end else begin
                        r_acc     <= w_acc_new;
                        r_state   <= DONE;
                        r_rsp_val <= w_acc_new;
                        r_rsp_vld <= 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_rdy) begin
                        r_state   <= IDLE;
                        r_rsp_vld <= 1'b0;
                        r_req_rdy <= 1'b1;
                        r_rfr     <= '0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_rsp_vld <= 1'b0;
                    r_req_rdy <= 1'b1;
                    r_rfr     <= '0;
                end
            endcase
        end
    end

    assign req_rdy = r_req_rdy;
    assign rfr     = r_rfr;
    assign rsp_vld = r_rsp_vld;
    assign rsp_val = r_rsp_val;

endmodule

// File: doc/mag_sar_search.md
# mag_sar_search

Successive-approximation search engine for unsigned magnitudes. It drives a trial reference `rfr` into an external magnitude comparator and consumes that comparator's `grt`/`lst` verdicts. From these it reconstructs, MSB first, the unknown value the comparator holds on its `val` input. It sits on the reference side of the comparator interface: the comparator answers, this block asks, one bit per clock.

## Interface
- `WIDTH`, default 32: width of the searched value, `rfr` and `rsp_val`. Minimum 1.
- `clk` in, 1: clock. All state updates on the rising edge.
- `rst_n` in, 1: reset. Asynchronous, active-low.
- `req_vld` in, 1: start-search request.
- `req_rdy` out, 1: block idle and able to accept a request.
- `rfr` out, `WIDTH`: registered trial reference driven to the comparator.
- `grt` in, 1: comparator verdict `val > rfr`, combinational from `rfr`.
- `lst` in, 1: comparator verdict `val < rfr`, combinational from `rfr`.
- `rsp_vld` out, 1: result valid.
- `rsp_rdy` in, 1: result consumer ready.
- `rsp_val` out, `WIDTH`: found value.

## Operation
- States:
  - `IDLE`: `req_rdy=1`.
  - `SRCH`: one bit resolved per cycle.
  - `DONE`: `rsp_vld=1`.
- Transitions:
  - IDLE→SRCH on `req_vld && req_rdy`. Load `acc=0`, bit index `idx=WIDTH-1`, `rfr = 1<<(WIDTH-1)`.
  - SRCH, each cycle: sample `grt`/`lst` against the current `rfr`.
    - `lst=1`: the trial bit is cleared in `acc`.
    - Otherwise: the trial bit is kept in `acc`.
    - If `idx>0`: decrement `idx`, then `rfr = acc_new | (1<<idx_new)`.
    - If `idx==0`: go to DONE with `rsp_val = acc_new`.
  - SRCH→DONE early on equality (`grt=0 && lst=0`), with `rsp_val = rfr`. Only when early exit is compiled in (see Configuration).
  - DONE→IDLE on `rsp_rdy`. `rsp_val` holds until then.
- `grt=1 && lst=1` is an illegal comparator response. `lst` has priority; the bit is cleared. No error output.
- `rfr` is 0 in IDLE. It holds its last trial value in DONE.
- `req_vld` is ignored outside IDLE. A request cannot be accepted in the same cycle as the `rsp` handshake.
- The comparator `val` must be stable from request acceptance until `rsp_vld`. Otherwise the result is undefined but the FSM still terminates.
- Width rule: all arithmetic is plain `WIDTH`-bit unsigned with no carries. `idx` is `$clog2(WIDTH)` bits wide, minimum 1.

## Timing
- Reset values: state IDLE, `req_rdy=1`, `rfr=0`, `rsp_vld=0`, `rsp_val=0`, internal `acc=0`, `idx=0`.
- Reset asserted mid-search or in DONE aborts immediately (asynchronously) to the reset values. No response is produced.
- Latency, measured from the request-accept edge E0:
  - `rsp_vld` rises after edge E`WIDTH`, i.e. exactly `WIDTH` cycles.
  - With early exit, `rsp_vld` rises after edge E`k`, where `k` is the first cycle sampling equality (1 ≤ k ≤ `WIDTH`).
- Comparator loop: `rfr` is registered and `grt`/`lst` are sampled in the same cycle. The external comparator path must close in one cycle.
- `rsp_rdy` held low: DONE persists indefinitely and `rsp_val`/`rsp_vld` are stable.
- Throughput: at most one search per `WIDTH+2` cycles. That is 1 accept cycle, `WIDTH` search cycles and 1 handshake cycle, with the return to IDLE costing one cycle.

## Configuration
- Macro: `MAG_SAR_SEARCH_EARLY_EXIT_EN`.
  - Defined: equality in SRCH terminates the search that cycle, with `rsp_val=rfr`. Latency is variable, from 1 to `WIDTH` cycles.
  - Undefined: equality is treated as "keep bit" (not `lst`). Latency is always exactly `WIDTH` cycles, and the result is identical.

## Structure
- Shared package `mag_pkg` holds:
  - state enum typedef `mag_sar_state_t` {`IDLE`, `SRCH`, `DONE`};
  - a helper function returning the one-hot trial mask for `idx`.
- Core has no sub-modules.
- A thin wrapper `mag_sar_top` instantiates `mag_sar_search` together with the existing comparator `mag_cmp_base` (`IMPLEMENTATION=0`). It exposes `val` as an input and is the natural verification top.

## Test plan
All cases use `WIDTH=8` through `mag_sar_top`.
- `val=0xA5`, `req_vld` pulse, early exit off: `rsp_vld` rises exactly 8 cycles after accept, with `rsp_val=0xA5`. The `rfr` trace is 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
- `val=0x80`, early exit on: `rsp_vld` rises 1 cycle after accept, with `rsp_val=0x80`. With early exit off, 8 cycles and `rsp_val=0x80`.
- Extreme values:
  - `val=0x00`: `rsp_val=0x00` after 8 cycles; every trial gives `lst`.
  - `val=0xFF`: `rsp_val=0xFF` after 8 cycles, or after 8 cycles with early exit at the final trial.
- `rsp_rdy` held low for 5 cycles after `rsp_vld`, with `req_vld` held high:
  - `rsp_val` is stable and `req_rdy=0` throughout.
  - After the handshake, a new request is accepted one cycle later.
- `rst_n` pulsed low at cycle 3 of a search:
  - All outputs show reset values with no clock edge required.
  - The next search (`val=0x3C`) returns 0x3C.
